// File: rtl/lock_disp_pkg.sv
// Shared types and constants for the canal lock water-level display path.
// Holds the scanner state/channel encodings and the saturation constant.
package lock_disp_pkg;

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    SHIFT  = 2'd1,
    WRITE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CH_INNER = 2'd0,
    CH_LOCK  = 2'd1,
    CH_OUTER = 2'd2
  } channel_t;

  localparam logic [7:0] SAT_BCD   = 8'h99;
  localparam int         SCRATCH_W = 12;

  // Round-robin order inner -> lock -> outer -> inner.
  function automatic channel_t next_channel(input channel_t ch);
    case (ch)
      CH_INNER: return CH_LOCK;
      CH_LOCK:  return CH_OUTER;
      default:  return CH_INNER;
    endcase
  endfunction

endpackage

// File: rtl/dabble_adjust.sv
// Add-3 correction of a three-digit BCD scratch ahead of each double-dabble shift.
// Purely combinational; every nibble >= 5 is bumped by 3.
module dabble_adjust
  import lock_disp_pkg::*;
(
  input  logic [SCRATCH_W-1:0] i_scratch,
  output logic [SCRATCH_W-1:0] o_scratch
);

  always_comb begin
    // NOTE: default the whole output first so no path through the loop leaves it unassigned (no latch).
    o_scratch = i_scratch;
    for (int d = 0; d < SCRATCH_W / 4; d++) begin
      if (i_scratch[4*d +: 4] >= 4'd5)
        o_scratch[4*d +: 4] = i_scratch[4*d +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/level_bcd_scanner.sv
// Round-robin binary-to-BCD converter for the three canal water levels, sharing one
// double-dabble engine; each channel refreshes every 3*(WIDTH+2) cycles, saturating at 99.
module level_bcd_scanner #(
  parameter int         WIDTH   = 8,
  parameter logic [7:0] SAT_BCD = lock_disp_pkg::SAT_BCD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] inner_level,
  input  logic [WIDTH-1:0] lock_level,
  input  logic [WIDTH-1:0] outer_level,
  output logic [7:0]       inner_bcd,
  output logic [7:0]       lock_bcd,
  output logic [7:0]       outer_bcd,
  output logic [2:0]       over,
  output logic             frame_done
);

  import lock_disp_pkg::*;

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  channel_t               r_channel;
  logic [WIDTH-1:0]       r_bin;
  logic [WIDTH-1:0]       w_level;
  logic [SCRATCH_W-1:0]   r_scratch;
  logic [SCRATCH_W-1:0]   w_adj;
  logic [CNT_W-1:0]       r_cnt;
  logic [7:0]             r_inner_bcd;
  logic [7:0]             r_lock_bcd;
  logic [7:0]             r_outer_bcd;
  logic [2:0]             r_over;
  logic                   r_frame_done;
  logic                   w_sat;
  logic [7:0]             w_digits;

  dabble_adjust u_dabble_adjust (
    .i_scratch (r_scratch),
    .o_scratch (w_adj)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (!reset_n) r_state <= SAMPLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SAMPLE:  w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_LAST) w_state_next = WRITE;
      WRITE:   w_state_next = SAMPLE;
      default: w_state_next = SAMPLE;
    endcase
  end

  always_comb begin
    w_level = inner_level;
    case (r_channel)
      CH_LOCK:  w_level = lock_level;
      CH_OUTER: w_level = outer_level;
      default:  w_level = inner_level;
    endcase
  end

  // Conversion datapath: capture in SAMPLE, adjust-then-shift in SHIFT, advance channel in WRITE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_channel <= CH_INNER;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        SAMPLE: begin
          r_bin     <= w_level;
          r_scratch <= '0;
          r_cnt     <= '0;
        end
        SHIFT: begin
          {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt              <= r_cnt + CNT_W'(1);
        end
        WRITE:   r_channel <= next_channel(r_channel);
        default: ;
      endcase
    end
  end

  assign w_sat    = |r_scratch[11:8];
  assign w_digits = w_sat ? SAT_BCD : r_scratch[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inner_bcd  <= 8'h00;
      r_lock_bcd   <= 8'h00;
      r_outer_bcd  <= 8'h00;
      r_over       <= 3'b000;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == WRITE) begin
        case (r_channel)
          CH_INNER: begin
            r_inner_bcd <= w_digits;
            r_over[0]   <= w_sat;
          end
          CH_LOCK: begin
            r_lock_bcd <= w_digits;
            r_over[1]  <= w_sat;
          end
          CH_OUTER: begin
            r_outer_bcd  <= w_digits;
            r_over[2]    <= w_sat;
            r_frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign inner_bcd  = r_inner_bcd;
  assign lock_bcd   = r_lock_bcd;
  assign outer_bcd  = r_outer_bcd;
  assign over       = r_over;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_level_bcd_scanner.sv
// Bench for level_bcd_scanner: directed steps plus random/exhaustive levels, every cycle
// compared against a frame-schedule reference model built from plain decimal arithmetic.
module tb_level_bcd_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] inner_level, lock_level, outer_level;
  logic [7:0] inner_bcd, lock_bcd, outer_bcd;
  logic [2:0] over;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: edge number since reset release, levels latched at each
  // channel's sample edge, and the expected displayed values.
  int         n_edge = 0;
  logic [7:0] pend [3];
  logic [7:0] exp_bcd [3];
  logic [2:0] exp_over = 3'b000;
  logic       exp_frame = 1'b0;

  always #5 clk = ~clk;

  level_bcd_scanner dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inner_level (inner_level),
    .lock_level  (lock_level),
    .outer_level (outer_level),
    .inner_bcd   (inner_bcd),
    .lock_bcd    (lock_bcd),
    .outer_bcd   (outer_bcd),
    .over        (over),
    .frame_done  (frame_done)
  );

  function automatic logic [7:0] to_bcd(input int v);
    int m;
    m = (v > 99) ? 99 : v;
    return 8'(((m / 10) << 4) | (m % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n_edge, got, exp);
    end
  endtask

  // Channel c is captured on edge 10c+1 of each 30-edge frame and shown on edge 10c+10.
  task automatic tick();
    logic [7:0] lv [3];
    logic       rs;
    int         pos;
    lv = '{inner_level, lock_level, outer_level};
    rs = reset_n;
    @(posedge clk);
    #1;
    if (!rs) begin
      n_edge    = 0;
      exp_bcd   = '{8'h00, 8'h00, 8'h00};
      exp_over  = 3'b000;
      exp_frame = 1'b0;
    end else begin
      n_edge++;
      pos       = (n_edge - 1) % 30;
      exp_frame = (pos == 29);
      for (int c = 0; c < 3; c++) begin
        if (pos == 10 * c) pend[c] = lv[c];
        if (pos == 10 * c + 9) begin
          exp_bcd[c]  = to_bcd(int'(pend[c]));
          exp_over[c] = (pend[c] > 8'd99);
        end
      end
    end
    chk("inner_bcd", inner_bcd, exp_bcd[0]);
    chk("lock_bcd", lock_bcd, exp_bcd[1]);
    chk("outer_bcd", outer_bcd, exp_bcd[2]);
    chk("over", {5'b0, over}, {5'b0, exp_over});
    chk("frame_done", {7'b0, frame_done}, {7'b0, exp_frame});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset held for 5 cycles with arbitrary levels.
    reset_n     = 1'b0;
    inner_level = 8'($urandom);
    lock_level  = 8'($urandom);
    outer_level = 8'($urandom);
    run(5);
    chk("rst_inner", inner_bcd, 8'h00);
    chk("rst_over", {5'b0, over}, 8'h00);
    chk("rst_frame", {7'b0, frame_done}, 8'h00);

    // 0 / 42 / 99: first frame completes at edge 30, frame_done at 30 and 60.
    inner_level = 8'd0;
    lock_level  = 8'd42;
    outer_level = 8'd99;
    reset_n     = 1'b1;
    run(29);
    chk("pre30_frame", {7'b0, frame_done}, 8'h00);
    tick();
    chk("f1_inner", inner_bcd, 8'h00);
    chk("f1_lock", lock_bcd, 8'h42);
    chk("f1_outer", outer_bcd, 8'h99);
    chk("f1_over", {5'b0, over}, 8'h00);
    chk("f1_frame30", {7'b0, frame_done}, 8'h01);
    tick();
    chk("f1_frame31", {7'b0, frame_done}, 8'h00);
    run(29);
    chk("f2_frame60", {7'b0, frame_done}, 8'h01);

    // Saturation: 100 / 255 / 7.
    do_reset();
    inner_level = 8'd100;
    lock_level  = 8'd255;
    outer_level = 8'd7;
    run(30);
    chk("sat_inner", inner_bcd, 8'h99);
    chk("sat_lock", lock_bcd, 8'h99);
    chk("sat_outer", outer_bcd, 8'h07);
    chk("sat_over", {5'b0, over}, 8'h03);

    // Lock level changes mid-SHIFT; the change waits for the next visit.
    do_reset();
    inner_level = 8'd0;
    lock_level  = 8'd10;
    outer_level = 8'd0;
    run(15);
    lock_level = 8'd55;
    run(5);
    chk("midshift_20", lock_bcd, 8'h10);
    run(29);
    chk("midshift_49", lock_bcd, 8'h10);
    tick();
    chk("midshift_50", lock_bcd, 8'h55);

    // Reset at edge 15 aborts the lock conversion and clears the inner display.
    do_reset();
    inner_level = 8'd37;
    run(14);
    chk("pre_abort_inner", inner_bcd, 8'h37);
    reset_n = 1'b0;
    tick();
    chk("abort_inner", inner_bcd, 8'h00);
    chk("abort_lock", lock_bcd, 8'h00);
    reset_n = 1'b1;
    run(9);
    chk("abort_inner_9", inner_bcd, 8'h00);
    tick();
    chk("abort_inner_10", inner_bcd, 8'h37);

    // Exhaustive: every value on every channel, each held for one full frame.
    do_reset();
    for (int v = 0; v < 256; v++) begin
      inner_level = 8'(v);
      lock_level  = 8'(v + 85);
      outer_level = 8'(v + 170);
      run(30);
    end

    // Random levels changing at arbitrary cycles.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       inner_level = 8'($urandom_range(0, 255));
          1:       lock_level  = 8'($urandom_range(0, 255));
          default: outer_level = 8'($urandom_range(0, 255));
        endcase
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_bcd_scanner.md
# level_bcd_scanner

Sequential binary-to-BCD display stage for the canal lock controller. It sits directly downstream of the lock system, consuming its three 8-bit water levels (inner, lock chamber, outer) and producing registered two-digit BCD values for the six seven-segment decoders. It time-multiplexes one shift-add-3 (double-dabble) engine across the three channels in round-robin order. Levels above 99 saturate to 99 with a per-channel overflow flag.

## Interface
- `WIDTH`, 8, bit width of each level input; shift phase lasts `WIDTH` cycles.
- `SAT_BCD`, 8'h99, BCD value driven when a level exceeds 99.
- `clk`  in  1  system clock, the divided lock clock; all state updates on its rising edge.
- `reset_n`  in  1  one clock; reset is synchronous and active-low.
- `inner_level`  in  WIDTH  inner water level, unsigned binary.
- `lock_level`  in  WIDTH  lock chamber water level, unsigned binary.
- `outer_level`  in  WIDTH  outer water level, unsigned binary.
- `inner_bcd`  out  8  [7:4] tens, [3:0] ones of inner level.
- `lock_bcd`  out  8  tens/ones of lock level.
- `outer_bcd`  out  8  tens/ones of outer level.
- `over`  out  3  saturation flags, bit 0 inner, bit 1 lock, bit 2 outer.
- `frame_done`  out  1  one-cycle pulse when all three channels have been refreshed.

## Operation
- State machine: SAMPLE -> SHIFT -> WRITE -> SAMPLE. Channel index cycles inner(0) -> lock(1) -> outer(2) -> inner.
- SAMPLE, 1 cycle: capture the selected channel's level into the binary shift register, clear the 12-bit BCD scratch (hundreds/tens/ones), and clear the shift counter.
- SHIFT, `WIDTH` cycles: per cycle, add 3 to every scratch nibble that is >= 5, then shift {scratch, binary} left by one bit. Exit when the counter reaches `WIDTH`-1.
- WRITE, 1 cycle: if the hundreds nibble is nonzero, drive `SAT_BCD` on the channel output and set its `over` bit. Otherwise drive {tens, ones} and clear its `over` bit. Then advance the channel, wrapping from 2 to 0.
- Only the channel being written changes. Other outputs hold.
- Inputs are sampled only in that channel's SAMPLE cycle. Changes during SHIFT/WRITE are ignored until the channel's next visit.
- `frame_done` is registered high for exactly the one cycle in which `outer_bcd` first shows its new value.
- Reset (reset_n=0 at an edge): state SAMPLE, channel 0, all `*_bcd`=8'h00, `over`=3'b000, `frame_done`=0, scratch and counter cleared. A reset mid-conversion aborts it with no partial write.

## Timing
- Per channel: 1 + `WIDTH` + 1 = 10 cycles. Full frame is 30 cycles at `WIDTH`=8.
- Edge 1 is the first rising edge with reset_n=1.
- `inner_bcd` updates at edge 10, `lock_bcd` at edge 20, `outer_bcd` at edge 30.
- `frame_done` is high from edge 30 to edge 31. Thereafter inner updates at 40, 70, …
- Latency from a level change to display is at most 40 cycles. This is the worst case: the change lands just after that channel's SAMPLE.
- Arithmetic: scratch is 12 bits, so the maximum input 255 yields 2,5,5 with no overflow of the scratch. Output saturation is decided solely by hundreds != 0.

## Structure
- Shared package `lock_disp_pkg`: state enum (SAMPLE, SHIFT, WRITE), channel enum (CH_INNER, CH_LOCK, CH_OUTER), `SAT_BCD` constant.
- Sub-module `dabble_adjust`: purely combinational add-3 correction on the 12-bit scratch, instantiated once.
- FSM, counter, channel mux and output registers live in `level_bcd_scanner`.

## Test plan
- Reset: hold reset_n=0 for 5 cycles with arbitrary inputs -> all `*_bcd`=00, `over`=000, `frame_done`=0.
- inner=0, lock=42, outer=99 -> at edge 30, outputs read 00/42/99 and `over`=000. `frame_done` is high only in cycle 30–31, then again 60–61.
- inner=100, lock=255, outer=7 -> inner 99, lock 99, outer 07; `over`=3'b011.
- lock=10, changed to 55 at edge 15 (mid-SHIFT) -> `lock_bcd`=10 at edge 20, 55 at edge 50.
- reset_n=0 at edge 15 for one cycle -> outputs 00 next edge. After release, `inner_bcd` updates exactly 10 edges later.
- Exhaustive: each value 0..255 on all channels, held for one frame -> outputs match the reference model (min(v,99) in BCD, over = v>99).
